// File: rtl/monitor_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling FSM, show-ahead byte FIFO,
// registered RTS flow control and one-cycle framing/overrun error pulses.
module monitor_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_rts,
  output logic                          frame_err,
  output logic                          overrun_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [3:0]    TICK_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    TICK_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RTS_LEVEL  = CW'(FIFO_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic            rxs;
  logic [DW-1:0]   div_cnt_reg, div_cnt_next;
  logic            tick, div_clr;
  logic [3:0]      tick_cnt_reg, tick_cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push_reg, push_next;
  logic            frame_err_reg, frame_err_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            rts_reg, overrun_reg;
  logic            pop, full, wr_en;

  assign rxs  = sync_reg[1];
  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync_reg      <= 2'b11;
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      tick_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], uart_rxd};
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      push_reg      <= push_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Divider restarts on the start edge so every sample lands mid-bit.
  always_comb begin
    div_cnt_next = div_cnt_reg + DW'(1);
    if (div_clr || tick) div_cnt_next = '0;
  end

  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    push_next      = 1'b0;
    frame_err_next = 1'b0;
    div_clr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next    = START;
          tick_cnt_next = '0;
          div_clr       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_reg == TICK_MID) begin
            tick_cnt_next = '0;
            bit_idx_next  = '0;
            state_next    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == TICK_LAST) begin
            shift_next   = {rxs, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == TICK_LAST) begin
            if (rxs) begin
              push_next  = 1'b1;
              state_next = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign pop   = rd_en && (count_reg != '0);
  assign full  = (count_reg == FULL_LEVEL);
  assign wr_en = push_reg && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rts_reg     <= 1'b1;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg   <= count_next;
      rts_reg     <= (count_reg >= RTS_LEVEL);
      overrun_reg <= push_reg && full && !pop;
    end
  end

  assign rd_valid    = (count_reg != '0);
  assign rd_data     = rd_valid ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_count  = count_reg;
  assign uart_rts    = rts_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_monitor_uart_rx.sv
// Directed bench for monitor_uart_rx: reset, single byte, glitch, framing error,
// FIFO overflow, push/pop on full, drain order and reset mid-frame.
module tb_monitor_uart_rx;

  // 50e6 / (16 * 325521) = 9.6, which the divider rounds to 10 clocks per tick.
  localparam int DIV       = 10;
  localparam int BIT_CLKS  = 16 * DIV;
  localparam int POP_DELAY = 3 + 152 * DIV;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       uart_rts;
  logic       frame_err;
  logic       overrun_err;

  int tests_run = 0;
  int tests_failed = 0;
  int frame_cnt = 0;
  int overrun_cnt = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  int ov_base;
  int fe_base;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  monitor_uart_rx #(
    .CLK_HZ    (50000000),
    .BAUD      (325521),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16),
    .RTS_MARGIN(4)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .uart_rxd   (uart_rxd),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .uart_rts   (uart_rts),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #10 clk50 = ~clk50;

  always @(negedge clk50) begin
    if (frame_err)                  frame_cnt   <= frame_cnt + 1;
    if (overrun_err)                overrun_cnt <= overrun_cnt + 1;
    if (frame_err && overrun_err)   overlap_cnt <= overlap_cnt + 1;
    if ((frame_err && fe_prev) || (overrun_err && ov_prev)) wide_cnt <= wide_cnt + 1;
    fe_prev <= frame_err;
    ov_prev <= overrun_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(negedge clk50);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk50);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      repeat (BIT_CLKS) @(negedge clk50);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk50);
    $display("[TB] frame 0x%02h stop=%0b count=%0d rts=%0b", data, stop_bit, fifo_count, uart_rts);
  endtask

  task automatic pop_byte();
    @(negedge clk50);
    rd_en = 1'b1;
    @(negedge clk50);
    rd_en = 1'b0;
    @(negedge clk50);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!rd_valid && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check_eq("rd_valid_within_budget", 32'(rd_valid), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk50);
    check_eq("rst_rts", 32'(uart_rts), 32'd1);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_data", 32'(rd_data), 32'h00);
    reset = 1'b1;
    @(negedge clk50);
    check_eq("rts_after_release", 32'(uart_rts), 32'd0);
    repeat (BIT_CLKS) @(negedge clk50);
    check_eq("idle_no_pulses", 32'(frame_cnt + overrun_cnt), 32'd0);

    // Single byte
    send_frame(8'hA5, 1'b1);
    wait_valid(3);
    check_eq("a5_data", 32'(rd_data), 32'hA5);
    check_eq("a5_count", 32'(fifo_count), 32'd1);
    pop_byte();
    check_eq("a5_pop_valid", 32'(rd_valid), 32'd0);
    check_eq("a5_pop_count", 32'(fifo_count), 32'd0);

    // 200 ns glitch
    @(negedge clk50);
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk50);
    uart_rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk50);
    $display("[TB] glitch 200ns count=%0d", fifo_count);
    check_eq("glitch_count", 32'(fifo_count), 32'd0);
    check_eq("glitch_frame_err", 32'(frame_cnt), 32'd0);

    // Framing error followed by held-low line, then good frame
    fe_base = frame_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk50);
    uart_rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk50);
    check_eq("ferr_pulses", 32'(frame_cnt - fe_base), 32'd1);
    check_eq("ferr_no_push", 32'(fifo_count), 32'd0);
    send_frame(8'h81, 1'b1);
    check_eq("after_break_data", 32'(rd_data), 32'h81);
    check_eq("after_break_count", 32'(fifo_count), 32'd1);
    check_eq("after_break_ferr", 32'(frame_cnt - fe_base), 32'd1);
    pop_byte();

    // Fill past capacity
    ov_base = overrun_cnt;
    for (int i = 0; i < 17; i++) begin
      int exp_cnt;
      exp_cnt = (i + 1 > 16) ? 16 : i + 1;
      send_frame(8'(i), 1'b1);
      check_eq("fill_count", 32'(fifo_count), 32'(exp_cnt));
      check_eq("fill_rts", 32'(uart_rts), (exp_cnt >= 12) ? 32'd1 : 32'd0);
    end
    check_eq("fill_overrun", 32'(overrun_cnt - ov_base), 32'd1);
    check_eq("full_head", 32'(rd_data), 32'h00);

    // Push while full with a pop on the same edge
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge clk50);
        repeat (POP_DELAY) @(posedge clk50);
        @(negedge clk50);
        rd_en = 1'b1;
        @(negedge clk50);
        rd_en = 1'b0;
      end
    join
    check_eq("pushpop_count", 32'(fifo_count), 32'd16);
    check_eq("pushpop_no_overrun", 32'(overrun_cnt - ov_base), 32'd1);
    check_eq("pushpop_head", 32'(rd_data), 32'h01);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_byte;
      exp_byte = (i < 15) ? 8'(i + 1) : 8'h55;
      check_eq("drain_data", 32'(rd_data), 32'(exp_byte));
      pop_byte();
      check_eq("drain_count", 32'(fifo_count), 32'(15 - i));
      check_eq("drain_rts", 32'(uart_rts), (15 - i >= 12) ? 32'd1 : 32'd0);
    end
    check_eq("drained_valid", 32'(rd_valid), 32'd0);

    // Reset in the middle of a frame, with one byte queued
    send_frame(8'h77, 1'b1);
    check_eq("pre_reset_count", 32'(fifo_count), 32'd1);
    @(negedge clk50);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk50);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = (i == 1) ? 1'b0 : 1'b1;
      repeat (BIT_CLKS) @(negedge clk50);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk50);
    $display("[TB] reset mid-frame count=%0d rts=%0b", fifo_count, uart_rts);
    check_eq("midrst_count", 32'(fifo_count), 32'd0);
    check_eq("midrst_valid", 32'(rd_valid), 32'd0);
    check_eq("midrst_rts", 32'(uart_rts), 32'd1);
    uart_rxd = 1'b1;
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk50);
    check_eq("midrst_rts_release", 32'(uart_rts), 32'd0);
    send_frame(8'hC3, 1'b1);
    check_eq("post_rst_data", 32'(rd_data), 32'hC3);
    check_eq("post_rst_count", 32'(fifo_count), 32'd1);

    // Pulse hygiene across the whole run
    check_eq("total_frame_err", 32'(frame_cnt), 32'd1);
    check_eq("total_overrun", 32'(overrun_cnt), 32'd1);
    check_eq("pulse_overlap", 32'(overlap_cnt), 32'd0);
    check_eq("pulse_width", 32'(wide_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
